data_mem_lsu: RTL and testbench

- Load/store unit between the CPU MEM stage and the single-port data memory (synchronous read, 1-cycle read latency, whole-word write, word-indexed address, no byte enables).
- Converts byte addresses to word indices and checks alignment and range.
- Loads: extracts and sign/zero-extends the addressed byte or halfword.
- Sub-word stores: performs read-modify-write, since the memory cannot write partial words.

---
 rtl/data_mem_lsu.sv | 128 ++++++++++++
 tb/tb_data_mem_lsu.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: load/store unit for a word-wide single-port data memory.
// Handles byte/half extraction on loads and read-modify-write for sub-word stores.
module data_mem_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    output logic                  err,
    output logic                  mem_request,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, LD_RESP, RMW_WRITE} state_t;
    localparam logic [ADDR_WIDTH-1:0] NUM_IDX = ADDR_WIDTH'(NUM_WORDS);

    state_t                state_q, state_d;
    logic                  err_q, err_d;
    logic [1:0]            off_q, off_d;
    logic [2:0]            f3_q, f3_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  misaligned, illegal, bad;
    logic [4:0]            sh;
    logic [DATA_WIDTH-1:0] lane, ext, mask, merged;

    assign req_idx    = {2'b00, req_addr[ADDR_WIDTH-1:2]};
    assign misaligned = (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                        (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'b00);
    assign illegal    = req_we ? (req_funct3 > 3'd2)
                               : (req_funct3[1:0] == 2'd3 || req_funct3 == 3'd6);
    assign bad        = misaligned || illegal || (req_idx >= NUM_IDX);

    // Lane offset in bits; words are aligned, so their shift is always zero.
    assign sh     = (f3_q[1:0] == 2'd0) ? {off_q, 3'b000} : {off_q[1], 4'b0000};
    assign lane   = mem_rdata >> sh;
    assign ext    = (f3_q[1:0] == 2'd0) ? {{24{~f3_q[2] & lane[7]}}, lane[7:0]}
                  : (f3_q[1:0] == 2'd1) ? {{16{~f3_q[2] & lane[15]}}, lane[15:0]}
                  : lane;
    assign mask   = ((f3_q[1:0] == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    assign merged = (mem_rdata & ~mask) | ((wdata_q << sh) & mask);

    assign req_ready = (state_q == IDLE);
    assign err       = err_q;

    always_comb begin
        state_d     = state_q;
        err_d       = 1'b0;
        off_d       = off_q;
        f3_d        = f3_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        rdata       = '0;
        rdata_valid = 1'b0;
        mem_request = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (rst_n) begin
            case (state_q)
                IDLE: if (req_valid) begin
                    if (bad) begin
                        err_d = 1'b1;
                    end else begin
                        mem_request = 1'b1;
                        mem_addr    = req_idx;
                        off_d       = req_addr[1:0];
                        f3_d        = req_funct3;
                        idx_d       = req_idx;
                        wdata_d     = req_wdata;
                        if (!req_we) begin
                            state_d = LD_RESP;
                        end else if (req_funct3 == 3'd2) begin
                            mem_we    = 1'b1;
                            mem_wdata = req_wdata;
                        end else begin
                            state_d = RMW_WRITE;
                        end
                    end
                end
                LD_RESP: begin
                    rdata_valid = 1'b1;
                    rdata       = ext;
                    state_d     = IDLE;
                end
                RMW_WRITE: begin
                    mem_request = 1'b1;
                    mem_we      = 1'b1;
                    mem_addr    = idx_q;
                    mem_wdata   = merged;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            off_q   <= '0;
            f3_q    <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: scoreboard bench for data_mem_lsu with a behavioural 128-word memory.
module tb_data_mem_lsu;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
    logic        req_ready, rdata_valid, err, mem_request, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;

    logic [31:0] mem [0:127];
    logic [31:0] exp_q [$];
    logic [31:0] exp_v;
    logic        acc_ready, acc_req, acc_we;
    int          checks = 0, errors = 0;

    data_mem_lsu dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rdata(rdata), .rdata_valid(rdata_valid), .err(err),
        .mem_request(mem_request), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_request && mem_addr < 32'd128) begin
            if (mem_we) mem[mem_addr[6:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[6:0]];
        end

    always @(negedge clk)
        if (rdata_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rdata_unexpected: got %h, no load outstanding", rdata);
            end else begin
                exp_v = exp_q.pop_front();
                if (rdata !== exp_v) begin
                    errors++;
                    $display("FAIL rdata: got %h, expected %h", rdata, exp_v);
                end
            end
        end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
        #1;
        while (!req_ready && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n == 10) begin
            errors++;
            $display("FAIL send_timeout: req_ready=%b after %0d cycles, expected 1", req_ready, n);
        end
        acc_ready = req_ready; acc_req = mem_request; acc_we = mem_we;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] e);
        exp_q.push_back(e);
        send(1'b0, f3, a, 32'h0);
        checks++;
        if (rdata_valid !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL ld_latency addr %h: valid=%b ready=%b, expected valid=1 ready=0", a, rdata_valid, req_ready);
        end
        step();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(); step();
        checks++;
        if ({req_ready, err, rdata_valid, mem_request, mem_we} !== 5'b10000 ||
            rdata !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
            errors++;
            $display("FAIL reset_outputs: rdy/err/val/req/we=%b rdata=%h addr=%h wdata=%h, expected 10000 and zeros",
                     {req_ready, err, rdata_valid, mem_request, mem_we}, rdata, mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back;
        send(1'b1, 3'd2, 32'h00, 32'h11);
        checks++;
        if ({acc_ready, acc_req, acc_we} !== 3'b111) begin
            errors++;
            $display("FAIL sw0_accept: rdy/req/we=%b, expected 111", {acc_ready, acc_req, acc_we});
        end
        send(1'b1, 3'd2, 32'h04, 32'h22);
        checks++;
        if ({acc_ready, acc_req, acc_we} !== 3'b111) begin
            errors++;
            $display("FAIL sw1_accept: rdy/req/we=%b, expected 111", {acc_ready, acc_req, acc_we});
        end
        checks++;
        if (mem[0] !== 32'h11 || mem[1] !== 32'h22) begin
            errors++;
            $display("FAIL sw_mem: words0/1=%h/%h, expected 00000011/00000022", mem[0], mem[1]);
        end
        load(3'd2, 32'h00, 32'h11);
        load(3'd2, 32'h04, 32'h22);
    endtask

    task automatic test_loads;
        send(1'b1, 3'd2, 32'h0C, 32'h876543A1);
        load(3'd2, 32'h0C, 32'h876543A1);
        load(3'd0, 32'h0C, 32'hFFFFFFA1);
        load(3'd4, 32'h0F, 32'h00000087);
        load(3'd1, 32'h0E, 32'hFFFF8765);
        load(3'd5, 32'h0E, 32'h00008765);
        load(3'd0, 32'h0E, 32'h00000065);
    endtask

    task automatic test_sub_word_store;
        send(1'b1, 3'd0, 32'h0D, 32'h123456FF);
        checks++;
        if (acc_req !== 1'b1 || acc_we !== 1'b0) begin
            errors++;
            $display("FAIL sb_read: req/we=%b%b, expected 10", acc_req, acc_we);
        end
        checks++;
        if (req_ready !== 1'b0 || mem_request !== 1'b1 || mem_we !== 1'b1 ||
            mem_addr !== 32'd3 || mem_wdata !== 32'h8765FFA1) begin
            errors++;
            $display("FAIL sb_write: rdy=%b req=%b we=%b addr=%h wdata=%h, expected 0 1 1 00000003 8765ffa1",
                     req_ready, mem_request, mem_we, mem_addr, mem_wdata);
        end
        load(3'd2, 32'h0C, 32'h8765FFA1);
        send(1'b1, 3'd1, 32'h0E, 32'h0000BEEF);
        load(3'd2, 32'h0C, 32'hBEEFFFA1);
    endtask

    task automatic err_case(input logic we, input logic [2:0] f3, input logic [31:0] a, input string name);
        send(we, f3, a, 32'hDEADBEEF);
        checks++;
        if (acc_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_noaccess: mem_request=%b, expected 0", name, acc_req);
        end
        checks++;
        if (err !== 1'b1 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_err: err=%b ready=%b, expected 1 1", name, err, req_ready);
        end
        step();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse: err=%b one cycle later, expected 0", name, err);
        end
    endtask

    task automatic test_errors;
        err_case(1'b1, 3'd1, 32'h0D, "sh_mis");
        err_case(1'b0, 3'd2, 32'h200, "lw_range");
        err_case(1'b0, 3'd3, 32'h08, "ld_f3");
        err_case(1'b1, 3'd4, 32'h08, "st_f3");
        err_case(1'b0, 3'd2, 32'h02, "lw_mis");
        load(3'd2, 32'h1FC, 32'h0);
    endtask

    task automatic test_reset_rmw;
        send(1'b1, 3'd1, 32'h02, 32'h0000BEEF);
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_request !== 1'b0) begin
            errors++;
            $display("FAIL rmw_reset_req: mem_request=%b, expected 0", mem_request);
        end
        step();
        checks++;
        if ({req_ready, err, rdata_valid, mem_request, mem_we} !== 5'b10000 ||
            rdata !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
            errors++;
            $display("FAIL rmw_reset_idle: rdy/err/val/req/we=%b, expected 10000", {req_ready, err, rdata_valid, mem_request, mem_we});
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (mem[0] !== 32'h11) begin
            errors++;
            $display("FAIL rmw_reset_mem: word0=%h, expected 00000011", mem[0]);
        end
        load(3'd2, 32'h00, 32'h11);
    endtask

    task automatic test_reset_load;
        send(1'b0, 3'd2, 32'h04, 32'h0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (rdata_valid !== 1'b0 || rdata !== 0) begin
            errors++;
            $display("FAIL ld_reset: valid=%b rdata=%h, expected 0 0", rdata_valid, rdata);
        end
        step();
        rst_n = 1'b1;
        step();
        load(3'd2, 32'h04, 32'h22);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '0;
        test_reset();
        test_back_to_back();
        test_loads();
        test_sub_word_store();
        test_errors();
        test_reset_rmw();
        test_reset_load();
        step(); step(); step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d loads outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
